deserializador_de_bytes: RTL and testbench

//   Upstream feeder for the bit-counting stage. Collects a serial bit stream

---
 rtl/deserializador_de_bytes_if.sv | 24 ++
 rtl/deserializador_de_bytes.sv | 110 +++++++++++
 tb/tb_deserializador_de_bytes.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/deserializador_de_bytes_if.sv
// Serial-in / word-out bundle for the byte deserializer.
// master = serial feeder and downstream reader; slave = the deserializer itself.
interface deserializador_de_bytes_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     serial_in;
    logic                     serial_vld;
    logic                     ready_in;
    logic [WIDTH-1:0]         data_out;
    logic                     valid_out;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    modport master (
        output serial_in, serial_vld, ready_in,
        input  data_out, valid_out, level, overflow
    );

    modport slave (
        input  serial_in, serial_vld, ready_in,
        output data_out, valid_out, level, overflow
    );
endinterface

// File: rtl/deserializador_de_bytes.sv
// Serial-to-word deserializer feeding a small register FIFO.
// Output handshake: a word transfers at a posedge where valid_out && ready_in; valid_out/data_out hold until then.
module deserializador_de_bytes #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    deserializador_de_bytes_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [WIDTH-1:0] shift_next;
    logic             word_done;
    logic             full;
    logic             pop;
    logic             push;

    always_comb begin
        shift_next = shift_q;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], bus.serial_in};
        end else begin
            shift_next = {bus.serial_in, shift_q[WIDTH-1:1]};
        end
    end

    assign word_done = bus.serial_vld && (bitcnt_q == CW'(WIDTH - 1));
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = (level_q != '0) && bus.ready_in;
    // A full FIFO still accepts the new word when the head leaves in the same cycle.
    assign push      = word_done && (!full || pop);

    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (bus.serial_vld) begin
            shift_d = shift_next;
            if (word_done) begin
                bitcnt_d = '0;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = shift_next;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (word_done && !push) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bitcnt_q   <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: it is only observable through rd_ptr while level != 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.valid_out = (level_q != '0);
    assign bus.data_out  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_deserializador_de_bytes.sv
// Directed bench for deserializador_de_bytes: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_deserializador_de_bytes;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  deserializador_de_bytes_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  deserializador_de_bytes #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_compared;
  int n_mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bit list assembled into words, FIFO as a queue
  logic [WIDTH-1:0] exp_q[$];
  logic             bits_q[$];
  logic             exp_ovf;

  always @(posedge clk) begin
    logic [WIDTH-1:0] w;
    logic             done;
    if (!reset) begin
      exp_q.delete();
      bits_q.delete();
      exp_ovf = 1'b0;
    end else begin
      done = 1'b0;
      w    = '0;
      if (bus.serial_vld) begin
        bits_q.push_back(bus.serial_in);
        if (bits_q.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = bits_q[i];
          bits_q.delete();
          done = 1'b1;
        end
      end
      if (exp_q.size() != 0 && bus.ready_in) void'(exp_q.pop_front());
      if (done) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else exp_ovf = 1'b1;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    check("valid_out", 32'(bus.valid_out), 32'(exp_q.size() != 0));
    check("data_out",  32'(bus.data_out),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("level",     32'(bus.level),     32'(exp_q.size()));
    check("overflow",  32'(bus.overflow),  32'(exp_ovf));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.serial_vld = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    bus.serial_in  = b;
    bus.serial_vld = 1'b1;
    tick();
    bus.serial_vld = 1'b0;
    bus.serial_in  = 1'b0;
  endtask

  task automatic send_byte(input logic [WIDTH-1:0] v, input int max_gap);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i], $urandom_range(0, max_gap));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic drain_one();
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] stream;
    logic [WIDTH-1:0] pops [4];
    n_compared     = 0;
    n_mismatched   = 0;
    exp_ovf        = 1'b0;
    reset          = 1'b0;
    bus.serial_in  = 1'b0;
    bus.serial_vld = 1'b0;
    bus.ready_in   = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.serial_in  = 1'($urandom_range(0, 1));
      bus.serial_vld = 1'($urandom_range(0, 1));
      bus.ready_in   = 1'($urandom_range(0, 1));
      tick();
    end
    check("t1_valid", 32'(bus.valid_out), 32'd0);
    check("t1_level", 32'(bus.level), 32'd0);
    check("t1_ovf",   32'(bus.overflow), 32'd0);
    check("t1_data",  32'(bus.data_out), 32'd0);
    bus.serial_vld = 1'b0;
    bus.ready_in   = 1'b0;
    reset          = 1'b1;
    tick();

    // 2: back-to-back bits 1,0,1,1,0,0,1,0
    stream = 8'hB2;
    send_byte(stream, 0);
    check("t2_valid", 32'(bus.valid_out), 32'd1);
    check("t2_data",  32'(bus.data_out), 32'hB2);
    check("t2_level", 32'(bus.level), 32'd1);
    drain_one();
    check("t2_empty", 32'(bus.valid_out), 32'd0);

    // 3: same stream with random gaps
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(stream[i], $urandom_range(0, 3));
    check("t3_no_early", 32'(bus.valid_out), 32'd0);
    send_bit(stream[0], $urandom_range(0, 3));
    check("t3_data",  32'(bus.data_out), 32'hB2);
    check("t3_level", 32'(bus.level), 32'd1);
    drain_one();

    // 4: overflow with five pushes, then in-order drain
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
    check("t4_level", 32'(bus.level), 32'd4);
    check("t4_ovf",   32'(bus.overflow), 32'd1);
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pops[i] = bus.data_out;
      tick();
    end
    bus.ready_in = 1'b0;
    for (int i = 0; i < 4; i++) check("t4_pop", 32'(pops[i]), 32'(i + 1));
    check("t4_empty", 32'(bus.valid_out), 32'd0);
    check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

    // 5: full FIFO, push and pop on the same edge
    do_reset();
    check("t5_ovf_clr", 32'(bus.overflow), 32'd0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 2);
    send_byte(8'h33, 0);
    send_byte(8'h44, 1);
    check("t5_full", 32'(bus.level), 32'd4);
    stream = 8'hAA;
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(stream[i], 0);
    bus.ready_in   = 1'b1;
    bus.serial_in  = stream[0];
    bus.serial_vld = 1'b1;
    tick();
    bus.serial_vld = 1'b0;
    bus.ready_in   = 1'b0;
    check("t5_level", 32'(bus.level), 32'd4);
    check("t5_ovf",   32'(bus.overflow), 32'd0);
    check("t5_head",  32'(bus.data_out), 32'h22);
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pops[i] = bus.data_out;
      tick();
    end
    bus.ready_in = 1'b0;
    check("t5_pop0", 32'(pops[0]), 32'h22);
    check("t5_pop1", 32'(pops[1]), 32'h33);
    check("t5_pop2", 32'(pops[2]), 32'h44);
    check("t5_pop3", 32'(pops[3]), 32'hAA);
    check("t5_empty", 32'(bus.valid_out), 32'd0);

    // 6: reset discards a partial word
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    do_reset();
    send_byte(8'h3C, 1);
    check("t6_level", 32'(bus.level), 32'd1);
    check("t6_data",  32'(bus.data_out), 32'h3C);
    drain_one();
    check("t6_empty", 32'(bus.valid_out), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_still_empty", 32'(bus.level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
